// File: rtl/controle_tentativas_if.sv
// controle_tentativas_if: signal bundle between the game logic and the password front-end
interface controle_tentativas_if #(
  parameter int MAX_TENTATIVAS = 5
);
  localparam int W = $clog2(MAX_TENTATIVAS + 1);
  logic         ENABLE;
  logic         BOTAO_ENTER;
  logic [3:0]   CHAVES;
  logic [3:0]   SENHA_A;
  logic [2:0]   SENHA_B;
  logic         TEMPO_ESGOTADO;
  logic [3:0]   TENTATIVA;
  logic         ENTER;
  logic         ACERTOU_SENHA_A;
  logic [W-1:0] TENTATIVAS_RESTANTES;
  logic         DESARMOU;
  logic         EXPLODIU;
  modport master (
    output ENABLE, BOTAO_ENTER, CHAVES, SENHA_A, SENHA_B, TEMPO_ESGOTADO,
    input  TENTATIVA, ENTER, ACERTOU_SENHA_A, TENTATIVAS_RESTANTES, DESARMOU, EXPLODIU
  );
  modport slave (
    input  ENABLE, BOTAO_ENTER, CHAVES, SENHA_A, SENHA_B, TEMPO_ESGOTADO,
    output TENTATIVA, ENTER, ACERTOU_SENHA_A, TENTATIVAS_RESTANTES, DESARMOU, EXPLODIU
  );
endinterface

// File: rtl/controle_tentativas.sv
// controle_tentativas: debounced password entry, two-phase check, attempt counter and defuse/explode outcome
module controle_tentativas #(
  parameter int MAX_TENTATIVAS  = 5,
  parameter int DEBOUNCE_CICLOS = 4
) (
  input logic CLOCK,
  input logic RESET_N,
  controle_tentativas_if.slave bus
);
  localparam int W  = $clog2(MAX_TENTATIVAS + 1);
  localparam int CW = $clog2(DEBOUNCE_CICLOS);
  typedef enum logic [1:0] {ESPERA_A, ESPERA_B, DESARMADA, EXPLODIDA} estado_t;
  estado_t estado, prox;
  logic [1:0] sync;
  logic nivel, nivel_q;
  logic [CW-1:0] cont;
  logic agendado, enter_r, espera, aceito;
  logic [3:0] tentativa_r;
  logic [W-1:0] rest, prox_rest;
  logic acertou, prox_acertou;
  assign espera = (estado == ESPERA_A) || (estado == ESPERA_B);
  assign aceito = nivel_q & ~nivel & bus.ENABLE & espera;
  // synchronize the button (idle high) and accept a level only after DEBOUNCE_CICLOS differing samples
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync    <= 2'b11;
      nivel   <= 1'b1;
      nivel_q <= 1'b1;
      cont    <= '0;
    end else begin
      sync    <= {sync[0], bus.BOTAO_ENTER};
      nivel_q <= nivel;
      if (sync[1] == nivel) cont <= '0;
      else if (cont == CW'(DEBOUNCE_CICLOS - 1)) begin
        nivel <= sync[1];
        cont  <= '0;
      end else cont <= cont + 1'b1;
    end
  end
  // latch the attempt, then strobe ENTER one cycle later so TENTATIVA is settled at its rising edge
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      tentativa_r <= '0;
      agendado    <= 1'b0;
      enter_r     <= 1'b0;
    end else begin
      tentativa_r <= aceito ? bus.CHAVES : tentativa_r;
      agendado    <= aceito;
      enter_r     <= agendado;
    end
  end
  // game state register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      estado  <= ESPERA_A;
      rest    <= W'(MAX_TENTATIVAS);
      acertou <= 1'b0;
    end else begin
      estado  <= prox;
      rest    <= prox_rest;
      acertou <= prox_acertou;
    end
  end
  // timeout wins over an evaluation; a wrong guess burns one attempt and the last one explodes
  always_comb begin
    prox         = estado;
    prox_rest    = rest;
    prox_acertou = acertou;
    if (espera && bus.TEMPO_ESGOTADO) prox = EXPLODIDA;
    else if (enter_r && estado == ESPERA_A && tentativa_r == bus.SENHA_A) begin
      prox         = ESPERA_B;
      prox_acertou = 1'b1;
    end else if (enter_r && estado == ESPERA_B && tentativa_r[2:0] == bus.SENHA_B) prox = DESARMADA;
    else if (enter_r && espera) begin
      prox_rest = rest - 1'b1;
      prox      = (rest == W'(1)) ? EXPLODIDA : estado;
    end
  end
  assign bus.TENTATIVA            = tentativa_r;
  assign bus.ENTER                = enter_r;
  assign bus.ACERTOU_SENHA_A      = acertou;
  assign bus.TENTATIVAS_RESTANTES = rest;
  assign bus.DESARMOU             = estado == DESARMADA;
  assign bus.EXPLODIU             = estado == EXPLODIDA;
endmodule

// File: tb/tb_controle_tentativas.sv
// tb_controle_tentativas: scoreboard bench with a game-level reference model
module tb_controle_tentativas;
  localparam int MAXT = 3;
  localparam int DEB = 4;
  localparam logic [3:0] SA = 4'd9;
  localparam logic [2:0] SB = 3'd5;
  logic CLOCK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLOCK = ~CLOCK;
  controle_tentativas_if #(.MAX_TENTATIVAS(MAXT)) bus ();
  controle_tentativas #(.MAX_TENTATIVAS(MAXT), .DEBOUNCE_CICLOS(DEB)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .bus(bus)
  );
  typedef struct {
    logic [3:0] t;
    logic acc_pre;
    int rest;
    logic acc, des, xp;
  } exp_t;
  exp_t q[$];
  exp_t pend;
  bit pend_v = 0;
  int nchk = 0, nerr = 0, ent_cnt = 0, exp_cnt = 0;
  int stage = 0, rem = MAXT;
  bit acc = 0;
  logic [3:0] last_t = '0, t_prev = '0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, req, $time);
    end
  endtask
  task automatic model_reset();
    stage = 0; rem = MAXT; acc = 0; last_t = '0;
  endtask
  // game rules at attempt level: stage 0 wants SENHA_A, stage 1 wants SENHA_B, 2 defused, 3 exploded
  task automatic model_press(logic [3:0] c, bit en, bit timeout, bit rst_abort);
    exp_t e;
    if (!en || stage >= 2) return;
    e.t = c;
    e.acc_pre = acc;
    last_t = c;
    if (rst_abort) model_reset();
    else if (timeout) stage = 3;
    else if (stage == 0 && c == SA) begin stage = 1; acc = 1; end
    else if (stage == 1 && c[2:0] == SB) stage = 2;
    else begin rem = rem - 1; if (rem == 0) stage = 3; end
    e.rest = rem; e.acc = acc; e.des = (stage == 2); e.xp = (stage == 3);
    q.push_back(e);
    exp_cnt++;
  endtask
  always @(negedge CLOCK) begin
    if (pend_v) begin
      chk("post_restantes", bus.TENTATIVAS_RESTANTES, pend.rest);
      chk("post_acertou", bus.ACERTOU_SENHA_A, pend.acc);
      chk("post_desarmou", bus.DESARMOU, pend.des);
      chk("post_explodiu", bus.EXPLODIU, pend.xp);
      pend_v = 0;
    end
    if (bus.ENTER === 1'b1) begin
      ent_cnt++;
      if (q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_enter: got ENTER=1 expected no strobe at %0t", $time);
      end else begin
        pend = q.pop_front();
        chk("tentativa_at_enter", bus.TENTATIVA, pend.t);
        chk("tentativa_before_enter", t_prev, pend.t);
        chk("acertou_at_enter", bus.ACERTOU_SENHA_A, pend.acc_pre);
        pend_v = 1;
      end
    end
    t_prev = bus.TENTATIVA;
  end
  task automatic do_reset();
    @(negedge CLOCK);
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_tentativa", bus.TENTATIVA, 0);
    chk("rst_enter", bus.ENTER, 0);
    chk("rst_acertou", bus.ACERTOU_SENHA_A, 0);
    chk("rst_restantes", bus.TENTATIVAS_RESTANTES, MAXT);
    chk("rst_desarmou", bus.DESARMOU, 0);
    chk("rst_explodiu", bus.EXPLODIU, 0);
    bus.BOTAO_ENTER = 1'b1;
    bus.TEMPO_ESGOTADO = 1'b0;
    repeat (3) @(negedge CLOCK);
    RESET_N = 1'b1;
    model_reset();
  endtask
  task automatic press(logic [3:0] c, bit en);
    @(negedge CLOCK);
    bus.CHAVES = c;
    bus.ENABLE = en;
    model_press(c, en, 0, 0);
    bus.BOTAO_ENTER = 1'b0;
    repeat (12) @(negedge CLOCK);
    bus.BOTAO_ENTER = 1'b1;
    repeat (12) @(negedge CLOCK);
    chk("enter_count", ent_cnt, exp_cnt);
  endtask
  task automatic bounce(int n, bit fixed);
    for (int i = 0; i < n; i++) begin
      bus.BOTAO_ENTER = 1'b0;
      repeat (fixed ? 2 : $urandom_range(1, 3)) @(negedge CLOCK);
      bus.BOTAO_ENTER = 1'b1;
      repeat (fixed ? 2 : $urandom_range(1, 3)) @(negedge CLOCK);
    end
    repeat (4) @(negedge CLOCK);
    chk("bounce_no_enter", ent_cnt, exp_cnt);
  endtask
  // press and act inside the ENTER cycle: mode 0 raises the timeout, mode 1 asserts reset
  task automatic press_race(logic [3:0] c, bit mode);
    bit found = 0;
    @(negedge CLOCK);
    bus.CHAVES = c;
    bus.ENABLE = 1'b1;
    model_press(c, 1, !mode, mode);
    bus.BOTAO_ENTER = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge CLOCK);
      found = (bus.ENTER === 1'b1);
    end
    if (!found) begin
      nchk++; nerr++;
      $display("FAIL enter_wait: got no ENTER within 30 cycles expected one");
    end else if (!mode) begin
      bus.TEMPO_ESGOTADO = 1'b1;
      @(negedge CLOCK);
      bus.TEMPO_ESGOTADO = 1'b0;
    end else begin
      #2 RESET_N = 1'b0;
      #1 chk("enter_drop_on_reset", bus.ENTER, 0);
      @(negedge CLOCK);
      bus.BOTAO_ENTER = 1'b1;
      repeat (2) @(negedge CLOCK);
      RESET_N = 1'b1;
    end
    bus.BOTAO_ENTER = 1'b1;
    repeat (12) @(negedge CLOCK);
    chk("enter_count", ent_cnt, exp_cnt);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [3:0] c;
    bus.ENABLE = 1'b1;
    bus.BOTAO_ENTER = 1'b1;
    bus.CHAVES = '0;
    bus.SENHA_A = SA;
    bus.SENHA_B = SB;
    bus.TEMPO_ESGOTADO = 1'b0;
    repeat (2) @(negedge CLOCK);
    do_reset();
    bounce(5, 1);
    press(4'd0, 1);
    do_reset();
    press(SA, 1);
    press(4'b1101, 1);
    bus.TEMPO_ESGOTADO = 1'b1;
    repeat (3) @(negedge CLOCK);
    bus.TEMPO_ESGOTADO = 1'b0;
    chk("defused_ignores_timeout_des", bus.DESARMOU, 1);
    chk("defused_ignores_timeout_exp", bus.EXPLODIU, 0);
    do_reset();
    repeat (4) press(4'd2, 1);
    do_reset();
    press_race(SA, 0);
    do_reset();
    press(4'd7, 0);
    chk("gated_tentativa", bus.TENTATIVA, last_t);
    press_race(SA, 1);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: c = SA;
        1: c = {1'($urandom), SB};
        default: c = 4'($urandom);
      endcase
      bounce($urandom_range(0, 3), 0);
      press(c, $urandom_range(0, 3) != 0);
      chk("tentativa_hold", bus.TENTATIVA, last_t);
      if (stage >= 2) do_reset();
    end
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/controle_tentativas.md
Name: controle_tentativas

Overview:
- Front-end controller for the bomb's password entry.
- Debounces the raw ENTER pushbutton and latches the switch value as the current attempt.
- Emits a one-cycle ENTER strobe for the greater/less hint stage, which is clocked on the rising edge of that strobe.
- Runs the two-phase password check (SENHA_A, then SENHA_B), counts remaining attempts and declares DESARMOU or EXPLODIU.

Parameters:
- MAX_TENTATIVAS, 5, wrong attempts allowed before explosion; must be ≥1.
- DEBOUNCE_CICLOS, 4, consecutive stable synchronized samples required to accept a button level change; must be ≥2. Board builds override with about 500000.

Ports:
- CLOCK  in  1  system clock; all state changes on its rising edge.
- RESET_N  in  1  reset, asynchronous assert, active-low.
- ENABLE  in  1  game running; when low, new presses are ignored.
- BOTAO_ENTER  in  1  raw pushbutton, active-low (0 = pressed), asynchronous to CLOCK.
- CHAVES  in  4  switch value to be latched as the attempt.
- SENHA_A  in  4  first password.
- SENHA_B  in  3  second password.
- TEMPO_ESGOTADO  in  1  countdown expired, level.
- TENTATIVA  out  4  last latched attempt; drives the hint stage.
- ENTER  out  1  registered one-cycle strobe; hint-stage clock.
- ACERTOU_SENHA_A  out  1  high once SENHA_A has been matched.
- TENTATIVAS_RESTANTES  out  $clog2(MAX_TENTATIVAS+1)  remaining wrong attempts.
- DESARMOU  out  1  bomb defused, sticky.
- EXPLODIU  out  1  bomb exploded, sticky.

Behaviour:
- Reset (RESET_N=0, takes effect immediately, no clock needed):
  - TENTATIVA=0, ENTER=0, ACERTOU_SENHA_A=0, TENTATIVAS_RESTANTES=MAX_TENTATIVAS, DESARMOU=0, EXPLODIU=0.
  - State ESPERA_A; debounced level = released; synchronizer and debounce counter cleared.
- Input conditioning:
  - BOTAO_ENTER passes through a 2-FF synchronizer.
  - The debounced level changes only after the synchronized value differs from it for DEBOUNCE_CICLOS consecutive cycles. Any sample equal to the debounced level clears the counter.
  - A press event is the debounced level going released→pressed, detected in cycle k. Release generates nothing. Holding the button generates exactly one event.
- Event accepted only if ENABLE=1 in cycle k and state is ESPERA_A or ESPERA_B; otherwise the event is dropped.
- Pipeline for an accepted event:
  - Edge k→k+1: TENTATIVA <= CHAVES.
  - Cycle k+2: ENTER=1 for exactly one cycle. TENTATIVA is stable and ACERTOU_SENHA_A still holds its pre-evaluation value at ENTER's rising edge.
  - Edge k+2→k+3: evaluation below updates the state and outputs.
  - Once started, the pipeline completes even if ENABLE drops.
  - DEBOUNCE_CICLOS≥2 guarantees no overlapping events.
- FSM:
  - ESPERA_A:
    - TENTATIVA==SENHA_A → ESPERA_B, ACERTOU_SENHA_A=1, counter unchanged.
    - Else decrement the counter; if it reaches 0 → EXPLODIDA.
  - ESPERA_B: compare TENTATIVA[2:0]==SENHA_B (MSB ignored).
    - Match → DESARMADA.
    - Else decrement the counter; if it reaches 0 → EXPLODIDA.
  - DESARMADA: DESARMOU=1; terminal until reset.
  - EXPLODIDA: EXPLODIU=1; terminal until reset.
- Timeout:
  - TEMPO_ESGOTADO=1 in ESPERA_A or ESPERA_B → EXPLODIDA on the next edge.
  - Timeout has priority over an evaluation on the same edge. ENTER is still emitted if already scheduled.
  - TEMPO_ESGOTADO is ignored in DESARMADA.
- The counter never underflows. DESARMOU and EXPLODIU are never both 1.
- SENHA_A and SENHA_B are sampled at the evaluation edge only.

Test Plan (MAX_TENTATIVAS=3, DEBOUNCE_CICLOS=4, SENHA_A=9, SENHA_B=5):
- Reset values: assert RESET_N mid-clock → all outputs at reset values immediately; TENTATIVAS_RESTANTES=3.
- Bounce rejection: toggle BOTAO_ENTER 0/1 every 2 cycles for 20 cycles → no ENTER. Then hold at 0 for 10 cycles → exactly one ENTER. Release and hold → no further ENTER.
- Correct defuse: CHAVES=9, press → TENTATIVA=9 one cycle before the ENTER pulse. ACERTOU_SENHA_A=0 during ENTER, 1 on the following cycle. Then CHAVES=4'b1101, press → DESARMOU=1, RESTANTES=3.
- Wrong attempts to explosion: CHAVES=2, press three times → RESTANTES goes 2, 1, 0; EXPLODIU=1 after the third evaluation; a fourth press yields no ENTER.
- Timeout race: TEMPO_ESGOTADO=1 on the same edge as a correct SENHA_A evaluation → EXPLODIU=1, ACERTOU_SENHA_A stays 0.
- Gating: ENABLE=0, press → no TENTATIVA change and no ENTER. RESET_N low during the ENTER cycle → ENTER drops immediately and state returns to ESPERA_A.
